// File: rtl/alu_mem_pipe_if.sv
// Bundle of request, result and read-port signals for alu_mem_pipe.
// master drives requests (in_valid..rd_addr); slave returns res/flags/rd_data.
interface alu_mem_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              wr_en;
    logic [2:0]        sel;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  res;
    logic              res_valid;
    logic              zero;
    logic              ovf;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;

    modport master (
        output in_valid, wr_en, sel, op1, op2, wr_addr, rd_en, rd_addr,
        input  res, res_valid, zero, ovf, rd_data, rd_valid
    );

    modport slave (
        input  in_valid, wr_en, sel, op1, op2, wr_addr, rd_en, rd_addr,
        output res, res_valid, zero, ovf, rd_data, rd_valid
    );
endinterface

// File: rtl/alu_mem_pipe.sv
// Registered ALU stage feeding a DEPTH x WIDTH result memory, plus a
// synchronous read port. Ports: clk, rst_n (async, active-low), bus (slave).
// Macro ALU_MEM_BYPASS_EN: write-first forwarding on read/write collision;
// undefined gives read-first (old contents).
module alu_mem_pipe #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    alu_mem_pipe_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  res_q;
    logic              res_valid_q;
    logic              zero_q;
    logic              ovf_q;
    logic              pend_v;
    logic [ADDR_W-1:0] pend_a;
    logic [WIDTH-1:0]  rd_q;
    logic              rd_valid_q;

    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  diff;
    logic [WIDTH-1:0]  alu_r;
    logic              alu_o;
    logic [WIDTH-1:0]  rd_word;

    // Overflow: operands agree in sign (ADD) or differ (SUB) and the
    // result sign departs from op1's sign.
    always_comb begin
        sum   = bus.op1 + bus.op2;
        diff  = bus.op1 - bus.op2;
        alu_r = '0;
        alu_o = 1'b0;
        case (bus.sel)
            3'b000: alu_r = bus.op1 & bus.op2;
            3'b001: alu_r = bus.op1 | bus.op2;
            3'b010: begin
                alu_r = sum;
                alu_o = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) &&
                        (sum[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            3'b110: begin
                alu_r = diff;
                alu_o = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) &&
                        (diff[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            3'b111: alu_r = {{(WIDTH-1){1'b0}},
                             ($signed(bus.op1) < $signed(bus.op2))};
            3'b100: alu_r = ~(bus.op1 | bus.op2);
            default: begin
                alu_r = '0;
                alu_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            pend_v      <= 1'b0;
            pend_a      <= '0;
        end else if (bus.in_valid) begin
            res_q       <= alu_r;
            res_valid_q <= 1'b1;
            zero_q      <= (alu_r == '0);
            ovf_q       <= alu_o;
            pend_v      <= bus.wr_en;
            pend_a      <= bus.wr_addr;
        end else begin
            res_valid_q <= 1'b0;
            pend_v      <= 1'b0;
        end
    end

    // Commit stage: res_q still holds the pending op's result here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (pend_v) begin
            mem[pend_a] <= res_q;
        end
    end

`ifdef ALU_MEM_BYPASS_EN
    always_comb begin
        rd_word = mem[bus.rd_addr];
        if (pend_v && (pend_a == bus.rd_addr)) rd_word = res_q;
    end
`else
    always_comb begin
        rd_word = mem[bus.rd_addr];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else if (bus.rd_en) begin
            rd_q       <= rd_word;
            rd_valid_q <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign bus.res       = res_q;
    assign bus.res_valid = res_valid_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.rd_data   = rd_q;
    assign bus.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_alu_mem_pipe.sv
// Scoreboard bench for alu_mem_pipe: directed cases then random traffic.
// Expected results come from an arithmetic reference model of the ALU/memory.
module tb_alu_mem_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    alu_mem_pipe_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    alu_mem_pipe #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        o;
    } alu_exp_t;

    alu_exp_t    aq[$];
    logic [31:0] rq[$];
    logic [31:0] mem_m [32];
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic [31:0] last_res;
    logic [31:0] last_rd;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic void ref_alu(input logic [2:0] s,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] r,
                                    output logic o);
        longint sa;
        longint sb;
        longint t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'd0;
        o  = 1'b0;
        case (s)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                t = sa + sb;
                r = t[31:0];
                o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd6: begin
                t = sa - sb;
                r = t[31:0];
                o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd7: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd4: r = ~(a | b);
            default: r = 32'd0;
        endcase
    endfunction

    // One clock of stimulus; the model advances exactly as the edge does.
    task automatic step(input logic iv, input logic we, input logic [2:0] s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic re,
                        input logic [4:0] ra);
        alu_exp_t e;
        logic [31:0] r;
        logic o;
        logic [31:0] v;
        bus.in_valid = iv;
        bus.wr_en    = we;
        bus.sel      = s;
        bus.op1      = a;
        bus.op2      = b;
        bus.wr_addr  = wa;
        bus.rd_en    = re;
        bus.rd_addr  = ra;
        if (re) begin
            v = mem_m[ra];
`ifdef ALU_MEM_BYPASS_EN
            if (pv && pa == ra) v = pd;
`endif
            rq.push_back(v);
        end
        if (pv) mem_m[pa] = pd;
        if (iv) begin
            ref_alu(s, a, b, r, o);
            e.r = r;
            e.z = (r == 32'd0);
            e.o = o;
            aq.push_back(e);
            pv = we;
            pa = wa;
            pd = r;
        end else begin
            pv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic rd(input logic [4:0] ra);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, ra);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_res", bus.res, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        aq.delete();
        rq.delete();
        for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
        pv = 1'b0;
        last_res = 32'd0;
        last_rd = 32'd0;
        bus.in_valid = 1'b0;
        bus.wr_en    = 1'b0;
        bus.sel      = 3'd0;
        bus.op1      = 32'd0;
        bus.op2      = 32'd0;
        bus.wr_addr  = 5'd0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = 5'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.res_valid) begin
                if (aq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL alu_extra: got res %h expected none",
                             bus.res);
                end else begin
                    alu_exp_t e;
                    e = aq.pop_front();
                    chk("alu_res", bus.res, e.r);
                    chk("alu_zero", {31'd0, bus.zero}, {31'd0, e.z});
                    chk("alu_ovf", {31'd0, bus.ovf}, {31'd0, e.o});
                    last_res = e.r;
                end
            end else begin
                chk("res_hold", bus.res, last_res);
            end
            if (bus.rd_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_extra: got rd_data %h expected none",
                             bus.rd_data);
                end else begin
                    logic [31:0] v;
                    v = rq.pop_front();
                    chk("rd_data", bus.rd_data, v);
                    last_rd = v;
                end
            end else begin
                chk("rd_hold", bus.rd_data, last_rd);
            end
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = 32'h7FFFFFFF;
            1: v = 32'h80000000;
            2: v = 32'($urandom_range(0, 15));
            3: v = 32'hFFFFFFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #2;
        do_reset();
        rd(5'd5);
        rd(5'd31);
        step(1'b1, 1'b1, 3'b111, 32'd1050, 32'd1150, 5'd1, 1'b0, 5'd0);
        idle();
        rd(5'd1);
        step(1'b1, 1'b0, 3'b110, 32'd1050, 32'd1150, 5'd15, 1'b0, 5'd0);
        rd(5'd15);
        step(1'b1, 1'b1, 3'b100, 32'd1050, 32'd1150, 5'd31, 1'b0, 5'd0);
        step(1'b1, 1'b0, 3'b010, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 3'b110, 32'd5, 32'd5, 5'd0, 1'b1, 5'd31);
        step(1'b1, 1'b0, 3'b011, 32'd9, 32'd3, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 3'b101, 32'd9, 32'd3, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b1, 3'b010, 32'd3, 32'd4, 5'd7, 1'b0, 5'd0);
        rd(5'd7);
        rd(5'd7);
        step(1'b1, 1'b1, 3'b010, 32'd4, 32'd5, 5'd2, 1'b0, 5'd0);
        do_reset();
        idle();
        rd(5'd2);
        rd(5'd7);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom),
                 3'($urandom), pick(), pick(),
                 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)));
            if (i == 250) do_reset();
        end
        idle();
        idle();
        idle();
        chk("alu_q_empty", aq.size(), 32'd0);
        chk("rd_q_empty", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
